// File: rtl/pipe_pkg.sv
// Shared widths and control-bit positions for the pipeline stage registers.
package pipe_pkg;
   localparam int STAGE_DATA_W  = 64;
   localparam int STAGE_CTRL_W  = 8;
   localparam int IF_ID_DATA_W  = 64;
   localparam int IF_ID_CTRL_W  = 1;
   localparam int ID_EX_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int EX_MEM_DATA_W = 64;
   localparam int EX_MEM_CTRL_W = 8;
   localparam int MEM_WB_DATA_W = 64;
   localparam int MEM_WB_CTRL_W = 7;

   localparam int REGWRITE_BIT  = 0;
   localparam int MEMTOREG_BIT  = 1;

   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction
endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus data/ctrl payload, with load and clear.
// Clear drops only the valid flag; the payload is left as it was.
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = STAGE_DATA_W,
   parameter int CTRL_W = STAGE_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              q_valid,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   // entry storage; clear wins over load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_data  <= {DATA_W{1'b0}};
         q_ctrl  <= {CTRL_W{1'b0}};
      end else if (clear) begin
         q_valid <= 1'b0;
      end else if (load) begin
         q_valid <= 1'b1;
         q_data  <= d_data;
         q_ctrl  <= d_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush and bubble gating.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a flopped in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W           = STAGE_DATA_W,
   parameter int CTRL_W           = STAGE_CTRL_W,
   parameter int BUBBLE_ZERO_DATA = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic              main_valid_r;
   logic [DATA_W-1:0] main_data_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic              main_load_s;
   logic              main_clear_s;
   logic [DATA_W-1:0] main_d_data_s;
   logic [CTRL_W-1:0] main_d_ctrl_s;
   logic              accept_s;
   logic              main_free_s;

   assign accept_s    = in_valid & in_ready;
   assign main_free_s = ~main_valid_r | out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic              skid_load_s;
   logic              skid_clear_s;
   logic              skid_next_s;
   logic              in_ready_r;

   // route: a held skid entry refills main first, otherwise the new beat does
   always_comb begin
      main_load_s  = ~flush & main_free_s & (skid_valid_r | accept_s);
      main_clear_s = flush | (main_free_s & ~skid_valid_r & ~accept_s);
      skid_load_s  = ~flush & ~main_free_s & accept_s;
      skid_clear_s = flush | (main_free_s & skid_valid_r);
      skid_next_s  = ~skid_clear_s & (skid_load_s | skid_valid_r);
      if (skid_valid_r) begin
         main_d_data_s = skid_data_r;
         main_d_ctrl_s = skid_ctrl_r;
      end else begin
         main_d_data_s = in_data;
         main_d_ctrl_s = in_ctrl;
      end
   end

   // in_ready comes straight from a flop so out_ready never reaches it combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b0;
      end else begin
         in_ready_r <= ~skid_next_s;
      end
   end

   assign in_ready = in_ready_r;

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (skid_load_s),
      .clear   (skid_clear_s),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .q_valid (skid_valid_r),
      .q_data  (skid_data_r),
      .q_ctrl  (skid_ctrl_r)
   );

   assign occupancy = occ_count(main_valid_r, skid_valid_r);
`else
   logic ready_en_r;

   // holds in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

   assign in_ready      = ready_en_r & main_free_s;
   assign main_load_s   = ~flush & accept_s;
   assign main_clear_s  = flush | (out_ready & ~accept_s);
   assign main_d_data_s = in_data;
   assign main_d_ctrl_s = in_ctrl;
   assign occupancy     = occ_count(main_valid_r, 1'b0);
`endif

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (main_load_s),
      .clear   (main_clear_s),
      .d_data  (main_d_data_s),
      .d_ctrl  (main_d_ctrl_s),
      .q_valid (main_valid_r),
      .q_data  (main_data_r),
      .q_ctrl  (main_ctrl_r)
   );

   assign out_valid = main_valid_r;

   // bubble gating: ctrl always, data only when BUBBLE_ZERO_DATA is set
   always_comb begin
      if (main_valid_r) begin
         out_ctrl = main_ctrl_r;
      end else begin
         out_ctrl = {CTRL_W{1'b0}};
      end
      if ((BUBBLE_ZERO_DATA != 0) && !main_valid_r) begin
         out_data = {DATA_W{1'b0}};
      end else begin
         out_data = main_data_r;
      end
   end

endmodule
